// File: rtl/stream_buf_pkg.sv
// stream_buf_pkg: shared types and mode constants for the stream buffer
package stream_buf_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} rx_state_e;
  localparam bit MODE_CUT = 1'b0;
  localparam bit MODE_SAF = 1'b1;
endpackage

// File: rtl/stream_buf_dut_ram.sv
// sync_fifo_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port
module sync_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  // storage is deliberately not reset; pointers alone define valid contents
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stream_buf_dut.sv
// stream_buf_dut: frame buffer between rx_dv/rxd and a valid/ready tx port, cut-through or store-and-forward
module stream_buf_dut
  import stream_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int STORE_FWD = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          rxd,
  input  logic                       rx_dv,
  output logic [DATA_W-1:0]          txd,
  output logic                       tx_en,
  output logic                       tx_last,
  input  logic                       tx_rdy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam bit SAF = (STORE_FWD != 0) ? MODE_SAF : MODE_CUT;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] pend_q;
  logic              pend_vld_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, commit_q, commit_d;
  logic [DATA_W-1:0] txd_q;
  logic              tx_en_q, tx_last_q, ovf_q, ovf_d;
  logic              full, wr_try, wr_en, wr_drop, readable, pop;
  entry_t            wr_entry, rd_entry;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_entry = '{last: !rx_dv, data: pend_q};
  assign readable = rd_ptr_q != (SAF ? commit_q : wr_ptr_q);
  assign pop      = readable && (!tx_en_q || tx_rdy);

  // input stage: hold each sampled byte one cycle so its last flag is known when written
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= rx_dv ? rxd : pend_q;
      pend_vld_q <= rx_dv;
    end

  // rx FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  // rx FSM next state; an overflow on the final byte goes straight to IDLE so the next frame is not swallowed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = rx_dv ? RECV : IDLE;
      RECV:    state_d = !rx_dv ? IDLE : wr_drop ? DISCARD : RECV;
      DISCARD: state_d = rx_dv ? DISCARD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rx FSM outputs: write the pending byte while receiving, drop it when full
  always_comb begin
    wr_try  = pend_vld_q && (state_q == RECV);
    wr_en   = wr_try && !full;
    wr_drop = wr_try && full;
  end

  // pointer, commit and overflow next-state; store-fwd rewinds a truncated frame to the last commit
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : (wr_drop && SAF) ? commit_q : wr_ptr_q;
    commit_d = (SAF && wr_en && !rx_dv) ? wr_ptr_q + 1'b1 : commit_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = wr_drop || (ovf_q && !clr_ovf);
  end

  // pointer and sticky overflow registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      commit_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      commit_q <= commit_d;
      ovf_q    <= ovf_d;
    end

  // registered output stage: reload on pop, otherwise hold until the beat is accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      txd_q     <= '0;
      tx_last_q <= 1'b0;
      tx_en_q   <= 1'b0;
    end else if (pop) begin
      txd_q     <= rd_entry.data;
      tx_last_q <= rd_entry.last;
      tx_en_q   <= 1'b1;
    end else if (tx_rdy) begin
      tx_en_q   <= 1'b0;
    end

  sync_fifo_ram #(.DEPTH(DEPTH), .W(DATA_W + 1)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  assign txd     = txd_q;
  assign tx_en   = tx_en_q;
  assign tx_last = tx_last_q;
  assign level   = wr_ptr_q - rd_ptr_q;
  assign ovf     = ovf_q;

  a_hold:  assert property (@(posedge clk) disable iff (rst) tx_en_q && !tx_rdy |=> $stable({tx_en_q, txd_q, tx_last_q}));
  a_level: assert property (@(posedge clk) disable iff (rst) level <= DEPTH_L);
  a_ovf:   assert property (@(posedge clk) disable iff (rst) $fell(ovf_q) |-> $past(clr_ovf));
endmodule

// File: tb/tb_stream_buf_dut.sv
// tb_stream_buf_dut: directed checks of cut-through, store-forward and small-depth overflow instances
module tb_stream_buf_dut;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] rxd = '0;
  logic       rx_dv = 1'b0, tx_rdy = 1'b0, clr_ovf = 1'b0;
  logic [7:0] ct_txd, sf_txd, sm_txd;
  logic       ct_en, ct_last, sf_en, sf_last, sm_en, sm_last;
  logic       ct_ovf, sf_ovf, sm_ovf;
  logic [4:0] ct_lvl, sf_lvl;
  logic [2:0] sm_lvl;
  int         vec_cnt = 0, miss_cnt = 0;
  logic [8:0] got[$];

  always #5 clk = ~clk;

  stream_buf_dut #(.DATA_W(8), .DEPTH(16), .STORE_FWD(0)) u_ct (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .txd(ct_txd), .tx_en(ct_en), .tx_last(ct_last),
    .tx_rdy(tx_rdy), .level(ct_lvl), .ovf(ct_ovf), .clr_ovf(clr_ovf));
  stream_buf_dut #(.DATA_W(8), .DEPTH(16), .STORE_FWD(1)) u_sf (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .txd(sf_txd), .tx_en(sf_en), .tx_last(sf_last),
    .tx_rdy(tx_rdy), .level(sf_lvl), .ovf(sf_ovf), .clr_ovf(clr_ovf));
  stream_buf_dut #(.DATA_W(8), .DEPTH(4), .STORE_FWD(1)) u_sm (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .txd(sm_txd), .tx_en(sm_en), .tx_last(sm_last),
    .tx_rdy(tx_rdy), .level(sm_lvl), .ovf(sm_ovf), .clr_ovf(clr_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic rdy);
    rx_dv = dv; rxd = d; tx_rdy = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rx_dv = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ct_out", {ct_en, ct_last, ct_txd}, 32'h0);
    chk("rst_ct_lvl", ct_lvl, 0);
    chk("rst_sm_ovf", sm_ovf, 0);
    rst = 1'b0;
    cyc(0, 0, 1);

    // frame 11,22,33 through cut-through and store-forward side by side
    cyc(1, 8'h11, 1);
    chk("t1_e0_ct_en", ct_en, 0);
    chk("t2_e0_sf_en", sf_en, 0);
    cyc(1, 8'h22, 1);
    chk("t1_e1_ct_en", ct_en, 0);
    chk("t1_e1_ct_lvl", ct_lvl, 1);
    cyc(1, 8'h33, 1);
    chk("t1_e2_ct", {ct_en, ct_last, ct_txd}, {22'd0, 2'b10, 8'h11});
    chk("t2_e2_sf_en", sf_en, 0);
    cyc(0, 0, 1);
    chk("t1_e3_ct", {ct_en, ct_last, ct_txd}, {22'd0, 2'b10, 8'h22});
    chk("t2_e3_sf_en", sf_en, 0);
    chk("t2_e3_sf_lvl", sf_lvl, 3);
    cyc(0, 0, 1);
    chk("t1_e4_ct", {ct_en, ct_last, ct_txd}, {22'd0, 2'b11, 8'h33});
    chk("t2_e4_sf", {sf_en, sf_last, sf_txd}, {22'd0, 2'b10, 8'h11});
    cyc(0, 0, 1);
    chk("t1_e5_ct_en", ct_en, 0);
    chk("t2_e5_sf", {sf_en, sf_last, sf_txd}, {22'd0, 2'b10, 8'h22});
    cyc(0, 0, 1);
    chk("t2_e6_sf", {sf_en, sf_last, sf_txd}, {22'd0, 2'b11, 8'h33});
    chk("t1_e6_ct_lvl", ct_lvl, 0);
    cyc(0, 0, 1);
    chk("t2_e7_sf_en", sf_en, 0);
    chk("t2_e7_sf_lvl", sf_lvl, 0);

    // backpressure: tx_rdy low on edges 4..8 of a 6-byte frame
    do_reset();
    for (int e = 0; e < 14; e++) begin
      logic rdy;
      rdy = !(e >= 4 && e <= 8);
      if (ct_en && rdy) got.push_back({ct_last, ct_txd});
      cyc(e < 6, 8'(8'hA0 + e), rdy);
      if (e >= 4 && e <= 8) chk("t3_hold", {ct_en, ct_last, ct_txd}, {22'd0, 2'b10, 8'hA1});
      if (e == 3) chk("t3_lvl_e3", ct_lvl, 1);
      if (e == 8) chk("t3_lvl_e8", ct_lvl, 4);
    end
    chk("t3_beats", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("t3_beat", got[i], {23'd0, (i == 5), 8'(8'hA0 + i)});
    chk("t3_ct_en_end", ct_en, 0);

    // small store-forward FIFO: 6-byte frame overflows and is rewound
    do_reset();
    for (int e = 0; e < 6; e++) begin
      cyc(1, 8'(8'hC0 + e), 0);
      chk("t4_sm_en", sm_en, 0);
      if (e == 3) chk("t4_ovf_e3", sm_ovf, 0);
      if (e == 4) chk("t4_lvl_e4", sm_lvl, 4);
      if (e == 5) chk("t4_ovf_e5", sm_ovf, 1);
      if (e == 5) chk("t4_lvl_e5", sm_lvl, 0);
    end
    cyc(0, 0, 1);
    chk("t4_e6_en", sm_en, 0);
    chk("t4_e6_lvl", sm_lvl, 0);
    cyc(1, 8'hAA, 1);
    cyc(1, 8'hBB, 1);
    cyc(0, 0, 1);
    chk("t4_e9_en", sm_en, 0);
    chk("t4_e9_lvl", sm_lvl, 2);
    cyc(0, 0, 1);
    chk("t4_e10", {sm_en, sm_last, sm_txd}, {22'd0, 2'b10, 8'hAA});
    cyc(0, 0, 1);
    chk("t4_e11", {sm_en, sm_last, sm_txd}, {22'd0, 2'b11, 8'hBB});
    cyc(0, 0, 1);
    chk("t4_e12_en", sm_en, 0);
    chk("t4_ovf_sticky", sm_ovf, 1);

    // clr_ovf coinciding with a fresh overflow loses; clr_ovf alone clears
    for (int e = 0; e < 6; e++) begin
      clr_ovf = (e == 5);
      cyc(1, 8'(8'hD0 + e), 1);
    end
    clr_ovf = 1'b0;
    chk("t5_set_wins", sm_ovf, 1);
    chk("t5_lvl", sm_lvl, 0);
    cyc(0, 0, 1);
    chk("t5_still_set", sm_ovf, 1);
    clr_ovf = 1'b1;
    cyc(0, 0, 1);
    clr_ovf = 1'b0;
    chk("t5_cleared", sm_ovf, 0);

    // async reset mid-frame, then a single-byte frame
    do_reset();
    for (int e = 0; e < 6; e++) cyc(1, 8'(8'hF0 + e), 1);
    chk("t6_pre_ct_en", ct_en, 1);
    chk("t6_pre_sm_ovf", sm_ovf, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ct_out", {ct_en, ct_last, ct_txd}, 32'h0);
    chk("t6_rst_ct_lvl", ct_lvl, 0);
    chk("t6_rst_sm_ovf", sm_ovf, 0);
    chk("t6_rst_sm_lvl", sm_lvl, 0);
    rx_dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 8'h5A, 1);
    cyc(0, 0, 1);
    chk("t6_e1_ct_en", ct_en, 0);
    chk("t6_e1_ct_lvl", ct_lvl, 1);
    cyc(0, 0, 1);
    chk("t6_e2_ct", {ct_en, ct_last, ct_txd}, {22'd0, 2'b11, 8'h5A});
    chk("t6_e2_sf", {sf_en, sf_last, sf_txd}, {22'd0, 2'b11, 8'h5A});
    cyc(0, 0, 1);
    chk("t6_e3_en", {ct_en, sf_en}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
